// File: rtl/dma_block_loader_if.sv
// Bus bundle for dma_block_loader: request/control inputs, input word stream and DMA command outputs.
// Stream handshake: a word moves when in_valid and in_ready are both 1 at a rising clk edge;
// in_ready never depends on in_valid, and a producer holds in_data stable until the word moves.
interface dma_block_loader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [11:0]           length;
  logic                  read_after;
  logic                  abort;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  dma_enable;
  logic                  dma_rw;
  logic [ADDR_WIDTH-1:0] dma_address;
  logic [DATA_WIDTH-1:0] dma_data;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport slave (
    input  start, base_addr, length, read_after, abort, in_valid, in_data,
    output in_ready, dma_enable, dma_rw, dma_address, dma_data, busy, done, err
  );

  modport master (
    output start, base_addr, length, read_after, abort, in_valid, in_data,
    input  in_ready, dma_enable, dma_rw, dma_address, dma_data, busy, done, err
  );
endinterface

// File: rtl/dma_block_loader.sv
// Streams a block of words into DMA word writes at base+n, optionally followed by one block-read command.
// state_dbg mirrors the FSM state: 0 IDLE, 1 WRITE, 2 READ, 3 FINISH.
module dma_block_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LEN    = 2500
) (
  input  logic               clk,
  input  logic               rst_n,
  dma_block_loader_if.slave  bus,
  output logic [1:0]         state_dbg
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    READ   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [11:0]           len_q;
  logic [11:0]           cnt;
  logic                  read_after_q;
  logic                  start_ok, start_zero, start_bad;
  logic                  accept, last_word, abort_act;

  assign bus.in_ready = (state == WRITE) && (cnt < len_q);
  assign bus.busy     = (state != IDLE);
  assign state_dbg    = state;

  assign start_ok   = (state == IDLE) && bus.start && (bus.length != 12'd0) && (bus.length <= MAX_LEN_W);
  assign start_zero = (state == IDLE) && bus.start && (bus.length == 12'd0);
  assign start_bad  = (state == IDLE) && bus.start && (bus.length > MAX_LEN_W);
  // Abort wins over a word offered on the same edge.
  assign accept     = bus.in_valid && bus.in_ready && !bus.abort;
  assign last_word  = (cnt + 12'd1) == len_q;
  assign abort_act  = bus.abort && ((state == WRITE) || (state == READ));

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_ok)        state_next = WRITE;
        else if (start_zero) state_next = FINISH;
      end
      WRITE: begin
        if (bus.abort)                  state_next = IDLE;
        else if (accept && last_word)   state_next = read_after_q ? READ : FINISH;
      end
      READ:    state_next = bus.abort ? IDLE : FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Command outputs are registered one edge behind the state that produces them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q          <= '0;
      len_q           <= '0;
      cnt             <= '0;
      read_after_q    <= 1'b0;
      bus.dma_enable  <= 1'b0;
      bus.dma_rw      <= 1'b0;
      bus.dma_address <= '0;
      bus.dma_data    <= '0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      bus.dma_enable <= 1'b0;
      bus.done       <= (state == FINISH);
      bus.err        <= start_bad || abort_act;
      if (start_ok) begin
        base_q       <= bus.base_addr;
        len_q        <= bus.length;
        read_after_q <= bus.read_after;
        cnt          <= '0;
      end
      if (accept) begin
        bus.dma_enable  <= 1'b1;
        bus.dma_rw      <= 1'b0;
        bus.dma_address <= base_q + ADDR_WIDTH'(cnt);
        bus.dma_data    <= bus.in_data;
        cnt             <= cnt + 12'd1;
      end
      if ((state == READ) && !bus.abort) begin
        bus.dma_enable  <= 1'b1;
        bus.dma_rw      <= 1'b1;
        bus.dma_address <= base_q;
      end
    end
  end
endmodule

// File: tb/tb_dma_block_loader.sv
// Directed bench for dma_block_loader: drivers push cycle-stamped expected commands/events,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_dma_block_loader;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int W  = 16 + 1 + AW + DW;
  localparam int EW = 16 + 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  int         cyc   = 0;
  int         tests = 0;
  int         fails = 0;

  logic [W-1:0]  exp_q[$];
  logic [EW-1:0] evt_q[$];

  dma_block_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dma_block_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LEN(2500)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  logic          last_rw   = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;
  logic [W-1:0]  e_cmd;
  logic [EW-1:0] e_evt;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rw   = 1'b0;
      last_addr = '0;
      last_data = '0;
    end else if (!clk) begin
      if (bus.dma_enable) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_cmd: got rw=%0b addr=%0h data=%0h at cycle %0d, expected no command",
                   bus.dma_rw, bus.dma_address, bus.dma_data, cyc);
        end else begin
          e_cmd = exp_q.pop_front();
          check("dma_cmd", 64'({16'(cyc), bus.dma_rw, bus.dma_address, bus.dma_data}), 64'(e_cmd));
        end
      end else begin
        check("dma_hold", 64'({bus.dma_rw, bus.dma_address, bus.dma_data}),
              64'({last_rw, last_addr, last_data}));
      end
      last_rw   = bus.dma_rw;
      last_addr = bus.dma_address;
      last_data = bus.dma_data;
      if (bus.done || bus.err) begin
        if (evt_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_evt: got done=%0b err=%0b at cycle %0d, expected none",
                   bus.done, bus.err, cyc);
        end else begin
          e_evt = evt_q.pop_front();
          check("done_err", 64'({16'(cyc), bus.done, bus.err}), 64'(e_evt));
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [11:0] l, input logic ra, output int t);
    t              = cyc;
    bus.start      = 1'b1;
    bus.base_addr  = b;
    bus.length     = l;
    bus.read_after = ra;
    tick();
    bus.start      = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    tick();
  endtask

  task automatic push_cmd(input int c, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({16'(c), rw, a, d});
  endtask

  task automatic push_evt(input int c, input logic dn, input logic er);
    evt_q.push_back({16'(c), dn, er});
  endtask

  task automatic drain(input string name);
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check({name, "_cmds_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_evts_left"}, 64'(evt_q.size()), 64'd0);
    check({name, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({bus.in_ready, bus.dma_enable, bus.dma_rw, bus.busy, bus.done, bus.err,
                     state_dbg, bus.dma_address, bus.dma_data}), 64'd0);
  endtask

  initial begin
    int t;
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.read_after = 1'b0;
    bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    #1;
    check_all_zero("reset_state");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Case 1: three back-to-back writes, no read
    do_start(16'h0010, 12'd3, 1'b0, t);
    check("c1_in_ready", 64'(bus.in_ready), 64'd1);
    check("c1_busy", 64'(bus.busy), 64'd1);
    push_cmd(t + 2, 1'b0, 16'h0010, 16'h0400);
    push_cmd(t + 3, 1'b0, 16'h0011, 16'h0800);
    push_cmd(t + 4, 1'b0, 16'h0012, 16'h1400);
    push_evt(t + 5, 1'b1, 1'b0);
    drive(1'b1, 16'h0400);
    drive(1'b1, 16'h0800);
    drive(1'b1, 16'h1400);
    drain("c1");

    // Case 2: address wrap, then block read at base
    do_start(16'hFFFF, 12'd2, 1'b1, t);
    push_cmd(t + 2, 1'b0, 16'hFFFF, 16'h1111);
    push_cmd(t + 3, 1'b0, 16'h0000, 16'h2222);
    push_cmd(t + 4, 1'b1, 16'hFFFF, 16'h2222);
    push_evt(t + 5, 1'b1, 1'b0);
    drive(1'b1, 16'h1111);
    drive(1'b1, 16'h2222);
    check("c2_state_read", 64'(state_dbg), 64'd2);
    check("c2_in_ready_read", 64'(bus.in_ready), 64'd0);
    drain("c2");

    // Case 3: bubbles on alternate cycles
    do_start(16'h0100, 12'd4, 1'b0, t);
    push_cmd(t + 2, 1'b0, 16'h0100, 16'hA001);
    push_cmd(t + 4, 1'b0, 16'h0101, 16'hA002);
    push_cmd(t + 6, 1'b0, 16'h0102, 16'hA003);
    push_cmd(t + 8, 1'b0, 16'h0103, 16'hA004);
    push_evt(t + 9, 1'b1, 1'b0);
    drive(1'b1, 16'hA001);
    drive(1'b0, 16'hBAD0);
    drive(1'b1, 16'hA002);
    drive(1'b0, 16'hBAD1);
    drive(1'b1, 16'hA003);
    drive(1'b0, 16'hBAD2);
    drive(1'b1, 16'hA004);
    drain("c3");

    // Case 4a: zero length goes straight to FINISH
    do_start(16'h0500, 12'd0, 1'b0, t);
    check("c4a_state_finish", 64'(state_dbg), 64'd3);
    push_evt(t + 2, 1'b1, 1'b0);
    drain("c4a");

    // Case 4b: length one above the limit
    do_start(16'h0500, 12'd2501, 1'b0, t);
    push_evt(t + 1, 1'b0, 1'b1);
    check("c4b_busy", 64'(bus.busy), 64'd0);
    tick();
    check("c4b_busy_after", 64'(bus.busy), 64'd0);
    drain("c4b");

    // Case 4c: length exactly at the limit is accepted; aborted after one word
    do_start(16'h1000, 12'd2500, 1'b0, t);
    check("c4c_busy", 64'(bus.busy), 64'd1);
    push_cmd(t + 2, 1'b0, 16'h1000, 16'h5A5A);
    push_evt(t + 3, 1'b0, 1'b1);
    drive(1'b1, 16'h5A5A);
    bus.abort = 1'b1;
    drive(1'b1, 16'h6B6B);
    bus.abort = 1'b0;
    drain("c4c");

    // Case 5: abort after three accepted words
    do_start(16'h0200, 12'd10, 1'b0, t);
    push_cmd(t + 2, 1'b0, 16'h0200, 16'hC001);
    push_cmd(t + 3, 1'b0, 16'h0201, 16'hC002);
    push_cmd(t + 4, 1'b0, 16'h0202, 16'hC003);
    push_evt(t + 5, 1'b0, 1'b1);
    drive(1'b1, 16'hC001);
    drive(1'b1, 16'hC002);
    drive(1'b1, 16'hC003);
    bus.abort = 1'b1;
    drive(1'b1, 16'hC004);
    bus.abort = 1'b0;
    check("c5_busy", 64'(bus.busy), 64'd0);
    check("c5_in_ready", 64'(bus.in_ready), 64'd0);
    drain("c5");

    // Case 6: asynchronous reset mid-WRITE, then a fresh transfer
    do_start(16'h0300, 12'd5, 1'b0, t);
    push_cmd(t + 2, 1'b0, 16'h0300, 16'hD001);
    push_cmd(t + 3, 1'b0, 16'h0301, 16'hD002);
    drive(1'b1, 16'hD001);
    drive(1'b1, 16'hD002);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("c6_async_reset");
    #1;
    rst_n = 1'b1;
    do_start(16'h0050, 12'd2, 1'b1, t);
    check("c6_restart_busy", 64'(bus.busy), 64'd1);
    push_cmd(t + 2, 1'b0, 16'h0050, 16'hE001);
    push_cmd(t + 3, 1'b0, 16'h0051, 16'hE002);
    push_cmd(t + 4, 1'b1, 16'h0050, 16'hE002);
    push_evt(t + 5, 1'b1, 1'b0);
    drive(1'b1, 16'hE001);
    drive(1'b1, 16'hE002);
    drain("c6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dma_block_loader.md
DMA_BLOCK_LOADER -- requirements
Module: dma_block_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, width of DMA word address.
REQ-002 Parameter DATA_WIDTH, default 16, width of one signed fixed-point word.
REQ-003 Parameter MAX_LEN, default 2500, largest legal transfer length in words.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  transfer request, sampled only in IDLE.
REQ-007 base_addr  input  ADDR_WIDTH  first DMA write address, captured on accepted start.
REQ-008 length  input  12  number of words to write, captured on accepted start.
REQ-009 read_after  input  1  when 1, issue one block-read command after the last write; captured on accepted start.
REQ-010 abort  input  1  terminate the current transfer.
REQ-011 in_valid  input  1  in_data holds a word.
REQ-012 in_data  input  DATA_WIDTH  word to store.
REQ-013 in_ready  output  1  loader accepts in_data this cycle.
REQ-014 dma_enable  output  1  DMA command strobe, one cycle per command.
REQ-015 dma_rw  output  1  1 = block read, 0 = word write.
REQ-016 dma_address  output  ADDR_WIDTH  write address.
REQ-017 dma_data  output  DATA_WIDTH  write data.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 done  output  1  one-cycle pulse when a transfer completes normally.
REQ-020 err  output  1  one-cycle pulse on an illegal length or an abort.

Function
REQ-021 FSM states SHALL be IDLE, WRITE, READ and FINISH.
REQ-022 IDLE with start=1 and 1<=length<=MAX_LEN SHALL capture base_addr, length and read_after, clear the word counter, and go to WRITE.
REQ-023 IDLE with start=1 and length=0 SHALL go to FINISH with no DMA command issued.
REQ-024 IDLE with start=1 and length>MAX_LEN SHALL pulse err the next cycle, stay in IDLE, and issue no DMA command.
REQ-025 in_ready SHALL be high exactly while state=WRITE and the word counter is below the captured length.
REQ-026 A word is accepted when in_valid and in_ready are both 1; the next cycle SHALL show dma_enable=1, dma_rw=0, dma_data=the accepted word, and dma_address=base+counter (latency 1).
REQ-027 The address sum SHALL wrap modulo 2^ADDR_WIDTH.
REQ-028 in_valid=0 SHALL insert a bubble: dma_enable=0 that cycle, with the counter and address held.
REQ-029 After the word with counter=length-1 is accepted, the FSM SHALL leave WRITE on that edge; it goes to READ if read_after=1, otherwise to FINISH.
REQ-030 READ SHALL last one cycle and drive dma_enable=1, dma_rw=1, dma_address=captured base_addr, then go to FINISH.
REQ-031 FINISH SHALL last one cycle, drive done=1, then return to IDLE.
REQ-032 When dma_enable=0, dma_rw, dma_address and dma_data SHALL hold their last values.
REQ-033 abort=1 in WRITE or READ SHALL force the next state to IDLE and pulse err.
REQ-034 On the abort edge no new word SHALL be accepted; a write already registered from the prior edge still completes, and no further commands follow.
REQ-035 abort in IDLE or FINISH SHALL be ignored.
REQ-036 start outside IDLE SHALL be ignored.
REQ-037 All outputs SHALL be registered except in_ready and busy, which are decoded from the state.

Reset
REQ-038 rst_n=0 SHALL, immediately and regardless of clk, force state=IDLE, counter=0, and in_ready, dma_enable, dma_rw, busy, done and err all to 0; dma_address and dma_data SHALL go to 0.
REQ-039 Reset asserted mid-transfer SHALL drop the transfer with no done or err pulse.
REQ-040 After rst_n rises, the first start SHALL be honoured on the first rising edge.

Verification
REQ-041 Case 1: base=0x0010, length=3, read_after=0, in_valid held 1 with data 0x0400, 0x0800, 0x1400 -> writes to 0x0010, 0x0011, 0x0012 on three consecutive cycles, then done one cycle later; no read issued.
REQ-042 Case 2: base=0xFFFF, length=2, read_after=1 -> writes to 0xFFFF then 0x0000, then one read cycle with dma_rw=1 and address 0xFFFF, then done.
REQ-043 Case 3: length=4 with in_valid low on alternate cycles -> exactly 4 writes, addresses contiguous, dma_enable low in the bubble cycles.
REQ-044 Case 4: length=0 -> done two cycles after start with no dma_enable; length=2501 -> single err pulse, busy stays 0.
REQ-045 Case 5: length=10, abort after 3 accepted words -> exactly 3 writes, err pulse, return to IDLE, no done.
REQ-046 Case 6: rst_n pulsed low mid-WRITE between clock edges -> outputs clear asynchronously, then a new start runs to completion normally.
